// File: rtl/piso_stream_serializer_if.sv
// Parallel-word / serial-bit bundle between a word producer, the serializer and the serial sink.
// The slave modport is the serializer's view; the master modport is the producer/sink view.
interface piso_stream_serializer_if #(
  parameter int N = 8
);
  logic [N-1:0] p_data;
  logic         p_valid;
  logic         p_ready;
  logic         shift_en;
  logic         so;
  logic         so_valid;
  logic         so_first;
  logic         so_last;
  logic         busy;

  modport slave (
    input  p_data, p_valid, shift_en,
    output p_ready, so, so_valid, so_first, so_last, busy
  );

  modport master (
    output p_data, p_valid, shift_en,
    input  p_ready, so, so_valid, so_first, so_last, busy
  );
endinterface

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out shifter: first bit one cycle after the handshake, one bit per shift_en strobe.
// p_ready is high in IDLE or on the last-bit strobe, so words chain back-to-back without an idle bit.
module piso_stream_serializer #(
  parameter int N          = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  piso_stream_serializer_if.slave  bus
);

  localparam int            CW   = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_shreg;
  logic [CW-1:0] r_bit_cnt;
  logic          r_so;

  logic          w_last;
  logic          w_ready;
  logic          w_load;
  logic          w_shift;
  logic          w_drain;
  logic [N-1:0]  w_shreg_shifted;
  logic          w_next_bit;
  logic          w_first_bit;

  assign w_last  = (r_bit_cnt == LAST);
  assign w_ready = (r_state == S_IDLE) || ((r_state == S_SHIFT) && bus.shift_en && w_last);
  assign w_load  = bus.p_valid && w_ready;
  assign w_shift = (r_state == S_SHIFT) && bus.shift_en && !w_last;
  // Last bit consumed with nothing queued behind it: the line returns to idle.
  assign w_drain = (r_state == S_SHIFT) && bus.shift_en && w_last && !bus.p_valid;

  // The output end is bit 0 for LSB-first, bit N-1 otherwise; vacated positions fill with 0.
  assign w_shreg_shifted = LSB_FIRST ? {1'b0, r_shreg[N-1:1]} : {r_shreg[N-2:0], 1'b0};
  assign w_next_bit      = LSB_FIRST ? w_shreg_shifted[0] : w_shreg_shifted[N-1];
  assign w_first_bit     = LSB_FIRST ? bus.p_data[0] : bus.p_data[N-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_drain) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.p_ready  = w_ready;
    bus.so_valid = 1'b0;
    bus.so_first = 1'b0;
    bus.so_last  = 1'b0;
    bus.busy     = 1'b0;
    if (r_state == S_SHIFT) begin
      bus.so_valid = 1'b1;
      bus.so_first = (r_bit_cnt == '0);
      bus.so_last  = w_last;
      bus.busy     = 1'b1;
    end
  end

  // r_so mirrors the output end of the shift register so the pin is a plain flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_so      <= IDLE_LEVEL;
    end else if (w_load) begin
      r_shreg   <= bus.p_data;
      r_bit_cnt <= '0;
      r_so      <= w_first_bit;
    end else if (w_shift) begin
      r_shreg   <= w_shreg_shifted;
      r_bit_cnt <= r_bit_cnt + CW'(1);
      r_so      <= w_next_bit;
    end else if (w_drain) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_so      <= IDLE_LEVEL;
    end
  end

  assign bus.so = r_so;

endmodule

// File: doc/piso_stream_serializer.md
Name: piso_stream_serializer

Overview:
- Parametrised parallel-in/serial-out shifter with a valid/ready handshake on the parallel side.
- Adds selectable bit order, an external bit-rate strobe, frame flags, and back-to-back word loading with no idle gap.
- Feeds serial links such as UART-style transmitters, SPI MOSI and LED chains from a word-oriented producer.

Parameters:
N, 8, word width in bits; N >= 2.
LSB_FIRST, 1, 1 = bit 0 is shifted out first; 0 = bit N-1 is shifted out first.
IDLE_LEVEL, 0, level driven on so when no word is being shifted.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
p_data  input  N  parallel word; sampled only on handshake
p_valid  input  1  producer has a word
p_ready  output  1  block accepts p_data this cycle (combinational)
shift_en  input  1  bit strobe; advances to the next bit when high
so  output  1  serial data (registered)
so_valid  output  1  so carries a data bit
so_first  output  1  current bit is the first of its word
so_last  output  1  current bit is the last of its word
busy  output  1  word in progress (state == SHIFT)

Behaviour:
- One clock, synchronous active-high reset; reset takes priority over every other input.
- Reset state: IDLE; shift register = 0; bit_cnt = 0; so = IDLE_LEVEL; so_valid = 0; so_first = 0; so_last = 0; busy = 0.
- Internal state: N-bit shift register, bit_cnt of width clog2(N), and a 2-state FSM (IDLE, SHIFT).
- p_ready = (state == IDLE) OR (state == SHIFT AND shift_en AND bit_cnt == N-1).
- Handshake occurs on any edge where p_valid AND p_ready.
- Handshake in IDLE: p_data loads, bit_cnt = 0, FSM goes to SHIFT.
  - On the next cycle, so shows the first bit (p_data[0] if LSB_FIRST, else p_data[N-1]).
  - Load-to-first-bit latency is 1 cycle.
- SHIFT with shift_en = 0: so and all flags hold. A bit lasts an arbitrary number of cycles.
- SHIFT with shift_en = 1 and bit_cnt < N-1: shift one position toward the output end and increment bit_cnt.
  - Vacated bit positions fill with 0.
- SHIFT with shift_en = 1 and bit_cnt == N-1 (last bit consumed):
  - If p_valid = 1: load the new word, set bit_cnt = 0, stay in SHIFT. The next word's first bit follows with no gap.
  - If p_valid = 0: go to IDLE; so = IDLE_LEVEL and so_valid = 0 from the next cycle.
- In SHIFT, so_valid = 1. so_first = (bit_cnt == 0). so_last = (bit_cnt == N-1). All three are 0 in IDLE.
- shift_en is ignored in IDLE.
- p_valid while in SHIFT and not on the last-bit strobe: p_ready = 0, the word is not taken, and the producer must hold it.
- Each bit is presented for at least one cycle and is consumed by exactly one shift_en strobe.
- Reset asserted mid-word: the word is discarded and the block returns to the reset state on the next edge, regardless of p_valid or shift_en.
- so must be driven directly from a flop (no combinational path to the pin).
- Only p_ready is combinational; it depends on state, bit_cnt and shift_en, never on p_valid.

Test Plan:
- Reset: hold reset 3 cycles while driving p_valid = 1 and shift_en = 1 -> so = IDLE_LEVEL, so_valid = 0, busy = 0, p_ready = 1 once reset is released.
- Single word, N = 8, LSB_FIRST = 1, p_data = 0xA5, shift_en = 1 every cycle -> so = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - so_first is high only on cycle 1; so_last is high only on cycle 8.
  - so_valid drops on cycle 9.
- Back-to-back: 0xA5 then 0x3C, with p_valid held through the last bit -> p_ready pulses with so_last.
  - so shows 16 contiguous valid bits: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - so_first is high on bits 1 and 9.
- Stall: shift_en low for 4 cycles while bit_cnt = 3 -> so, so_valid and so_first/so_last hold unchanged.
  - Stream then resumes with bit 4; total word length is still 8 strobes.
- Order, p_data = 0xC1:
  - LSB_FIRST = 0 -> so = 1,1,0,0,0,0,0,1.
  - LSB_FIRST = 1 -> so = 1,0,0,0,0,0,1,1.
- Busy rejection and mid-word reset:
  - Raise p_valid with 0xFF at bit_cnt = 2 -> p_ready = 0 and the current word continues unchanged.
  - Assert reset at bit_cnt = 5 -> next cycle busy = 0 and so = IDLE_LEVEL; the 0xFF word is accepted only after reset is released.
